// File: rtl/libhdl_fifo_burst_rd.sv
// Drains a valid/ready FIFO read port and re-issues its words as framed bursts of BURST_LEN beats, with short-burst flush on idle timeout.
// Latency: one cycle for the burst decision, then one cycle from FIFO pop to o_vld; 1 beat/cycle steady state.
// Backpressure: i_rdy low holds o_vld/o_dat/o_last and drops o_fifo_rrdy; an i_fifo_rvld drop stalls the burst without aborting it.
`timescale 1ns/1ps
module libhdl_fifo_burst_rd #(
    parameter int DATA_LEN  = 32,
    parameter int BURST_LEN = 16,
    parameter int CNT_LEN   = 11,
    parameter int TIMEOUT   = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_fifo_rvld,
    input  logic [DATA_LEN-1:0] i_fifo_rdat,
    output logic                o_fifo_rrdy,
    input  logic [CNT_LEN-1:0]  i_fifo_count,
    output logic                o_vld,
    output logic [DATA_LEN-1:0] o_dat,
    output logic                o_last,
    input  logic                i_rdy,
    output logic                o_busy,
    output logic                o_flush
);

    // Beat counter must hold BURST_LEN itself; the idle timer needs at least
    // one bit even when the partial flush is disabled (TIMEOUT == 0).
    localparam int REM_W = $clog2(BURST_LEN + 1);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_LEN-1:0] BURST_CNT = CNT_LEN'(BURST_LEN);
    localparam logic [REM_W-1:0]   REM_FULL  = REM_W'(BURST_LEN);
    localparam logic [REM_W-1:0]   REM_ONE   = REM_W'(1);
    localparam logic [TMR_W-1:0]   TMR_FIRE  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(TIMEOUT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [REM_W-1:0] rem;

    logic pop_hs;
    logic out_hs;
    logic cnt_nz;
    logic cnt_full;
    logic cnt_part;
    logic tmo_hit;

    // Fill-level qualifiers for the IDLE decision.
    assign cnt_nz   = |i_fifo_count;
    assign cnt_full = (i_fifo_count >= BURST_CNT);
    assign cnt_part = cnt_nz && !cnt_full;
    assign tmo_hit  = (TIMEOUT != 0) && cnt_nz && (tmr == TMR_FIRE);

    // Pop whenever beats remain and the output register is empty or draining
    // this cycle; this is the only combinational path from i_rdy.
    assign o_fifo_rrdy = (state == ST_BURST) && (rem != '0) && (!o_vld || i_rdy);
    assign pop_hs      = i_fifo_rvld && o_fifo_rrdy;
    assign out_hs      = o_vld && i_rdy;

    // Burst sequencer: idle timer, beat counter and the registered output stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            tmr     <= '0;
            rem     <= '0;
            o_vld   <= 1'b0;
            o_dat   <= '0;
            o_last  <= 1'b0;
            o_busy  <= 1'b0;
            o_flush <= 1'b0;
        end else begin
            o_flush <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cnt_full) begin
                        // A full burst wins over a timeout landing in the same cycle.
                        state  <= ST_BURST;
                        o_busy <= 1'b1;
                        rem    <= REM_FULL;
                        tmr    <= '0;
                    end else if (tmo_hit) begin
                        // Count is below BURST_LEN here, so it fits the beat counter.
                        state   <= ST_BURST;
                        o_busy  <= 1'b1;
                        rem     <= REM_W'(i_fifo_count);
                        o_flush <= 1'b1;
                        tmr     <= '0;
                    end else if (cnt_part) begin
                        if (tmr != TMR_MAX) begin
                            tmr <= tmr + 1'b1;
                        end
                    end else begin
                        tmr <= '0;
                    end
                end
                ST_BURST: begin
                    tmr <= '0;
                    if (pop_hs) begin
                        // Load a fresh beat; also covers drain-and-reload in one cycle.
                        o_dat  <= i_fifo_rdat;
                        o_vld  <= 1'b1;
                        rem    <= rem - 1'b1;
                        o_last <= (rem == REM_ONE);
                    end else if (out_hs) begin
                        o_vld  <= 1'b0;
                        o_last <= 1'b0;
                        if (o_last) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_libhdl_fifo_burst_rd.sv
// Directed bench for libhdl_fifo_burst_rd: behavioural FIFO model on the read side, beat capture on the output side.
// Latency: expected cycle offsets are hand-derived from BURST_LEN=4, TIMEOUT=8.
// Backpressure: i_rdy driven from a fixed 1,0,0,1 pattern in the stall test.
`timescale 1ns/1ps
module tb_libhdl_fifo_burst_rd;

    localparam int DW = 32;
    localparam int BL = 4;
    localparam int CW = 8;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic          fifo_rvld;
    logic [DW-1:0] fifo_rdat;
    logic          fifo_rrdy;
    logic [CW-1:0] fifo_count;
    logic          dut_vld;
    logic [DW-1:0] dut_dat;
    logic          dut_last;
    logic          rdy;
    logic          dut_busy;
    logic          dut_flush;

    logic          z_rrdy;
    logic          z_vld;
    logic [DW-1:0] z_dat;
    logic          z_last;
    logic          z_busy;
    logic          z_flush;

    libhdl_fifo_burst_rd #(
        .DATA_LEN(DW), .BURST_LEN(BL), .CNT_LEN(CW), .TIMEOUT(TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fifo_rvld  (fifo_rvld),
        .i_fifo_rdat  (fifo_rdat),
        .o_fifo_rrdy  (fifo_rrdy),
        .i_fifo_count (fifo_count),
        .o_vld        (dut_vld),
        .o_dat        (dut_dat),
        .o_last       (dut_last),
        .i_rdy        (rdy),
        .o_busy       (dut_busy),
        .o_flush      (dut_flush)
    );

    // Partial flush disabled: a constant short fill must never produce output.
    libhdl_fifo_burst_rd #(
        .DATA_LEN(DW), .BURST_LEN(BL), .CNT_LEN(CW), .TIMEOUT(0)
    ) dut_noto (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fifo_rvld  (1'b1),
        .i_fifo_rdat  (32'h5A5A_5A5A),
        .o_fifo_rrdy  (z_rrdy),
        .i_fifo_count (8'd3),
        .o_vld        (z_vld),
        .o_dat        (z_dat),
        .o_last       (z_last),
        .i_rdy        (1'b1),
        .o_busy       (z_busy),
        .o_flush      (z_flush)
    );

    // Clock, period 10.
    always begin
        clk = 1'b0;
        #5;
        clk = 1'b1;
        #5;
    end

    // Monitor state (written only by the monitor processes).
    int            cyc = 0;
    logic          pop_n = 1'b0;
    logic [DW-1:0] cap_dat[$];
    bit            cap_last[$];
    int            cap_edge[$];
    int            busy_cnt = 0;
    int            flush_cnt = 0;
    int            flush_cyc = 0;
    int            stall_viol = 0;
    int            hold_viol = 0;
    int            z_act = 0;
    logic          prev_vld = 1'b0;
    logic          prev_rdy = 1'b1;
    logic [DW-1:0] prev_dat = '0;
    logic          prev_last = 1'b0;

    // Edge counter used to time-stamp events.
    always @(posedge clk) begin
        cyc = cyc + 1;
    end

    // Mid-cycle sampling of handshakes, held-data rule and activity counters.
    always @(negedge clk) begin
        pop_n = fifo_rvld && fifo_rrdy;
        if (dut_vld && rdy) begin
            cap_dat.push_back(dut_dat);
            cap_last.push_back(dut_last);
            cap_edge.push_back(cyc + 1);
        end
        if (dut_vld && !rdy && fifo_rrdy) stall_viol = stall_viol + 1;
        if (prev_vld && !prev_rdy && !rst &&
            (!dut_vld || dut_dat != prev_dat || dut_last != prev_last)) hold_viol = hold_viol + 1;
        prev_vld  = dut_vld;
        prev_rdy  = rdy;
        prev_dat  = dut_dat;
        prev_last = dut_last;
        if (dut_busy) busy_cnt = busy_cnt + 1;
        if (dut_flush) begin
            flush_cnt = flush_cnt + 1;
            flush_cyc = cyc;
        end
        if (z_vld || z_rrdy || z_busy || z_flush) z_act = z_act + 1;
    end

    // Stimulus-side state (written only by the main process).
    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] q[$];
    logic          starve;
    logic          rdy_mode;
    logic [3:0]    pat;
    int            pc;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive();
        fifo_count = CW'(q.size());
        fifo_rvld  = (q.size() != 0) && !starve;
        fifo_rdat  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        q.push_back(d);
        drive();
    endtask

    // Advance one clock; apply the pop seen mid-cycle and refresh inputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (pop_n && q.size() != 0) void'(q.pop_front());
        if (rdy_mode) begin
            rdy = pat[pc % 4];
            pc  = pc + 1;
        end else begin
            rdy = 1'b1;
        end
        drive();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while ((q.size() != 0 || dut_busy || dut_vld) && k < budget) begin
            tick();
            k = k + 1;
        end
        check_val($sformatf("%s_done", tag), {61'd0, q.size() != 0, dut_busy, dut_vld}, 64'd0);
    endtask

    task automatic chk_burst(input string tag, input int base, input int n, input logic [DW-1:0] d0);
        check_val($sformatf("%s_nbeats", tag), 64'(cap_dat.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < cap_dat.size()) begin
                check_val($sformatf("%s_dat%0d", tag, i), 64'(cap_dat[base + i]), 64'(d0 + DW'(i)));
                check_val($sformatf("%s_last%0d", tag, i), 64'(cap_last[base + i]), 64'(i == n - 1));
            end
        end
    endtask

    task automatic wait_beats(input string tag, input int base, input int n);
        int k;
        k = 0;
        while (cap_dat.size() - base < n && k < 50) begin
            tick();
            k = k + 1;
        end
        check_val($sformatf("%s_reach", tag), 64'(cap_dat.size() - base >= n), 64'd1);
    endtask

    initial begin
        int b;
        int bc;
        int fc;
        int sv;
        int hv;
        int push_cyc;

        rst      = 1'b1;
        starve   = 1'b0;
        rdy_mode = 1'b0;
        pat      = 4'b1001;
        pc       = 0;
        rdy      = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_vld",   64'(dut_vld),   64'd0);
        check_val("rst_last",  64'(dut_last),  64'd0);
        check_val("rst_dat",   64'(dut_dat),   64'd0);
        check_val("rst_rrdy",  64'(fifo_rrdy), 64'd0);
        check_val("rst_busy",  64'(dut_busy),  64'd0);
        check_val("rst_flush", 64'(dut_flush), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Full burst, free-flowing output.
        b = cap_dat.size(); bc = busy_cnt; fc = flush_cnt;
        for (int i = 0; i < 4; i++) push(32'hA000_0000 + DW'(i));
        wait_done("full", 40);
        chk_burst("full", b, 4, 32'hA000_0000);
        check_val("full_busy",  64'(busy_cnt - bc),  64'd5);
        check_val("full_flush", 64'(flush_cnt - fc), 64'd0);
        if (cap_edge.size() >= b + 4)
            check_val("full_span", 64'(cap_edge[b + 3] - cap_edge[b]), 64'd3);
        tick();

        // Back-pressure with i_rdy 1,0,0,1,...
        b = cap_dat.size(); sv = stall_viol; hv = hold_viol;
        rdy_mode = 1'b1; pc = 0;
        for (int i = 0; i < 4; i++) push(32'hB000_0000 + DW'(i));
        wait_done("bp", 60);
        rdy_mode = 1'b0;
        tick();
        chk_burst("bp", b, 4, 32'hB000_0000);
        check_val("bp_rrdy_stall", 64'(stall_viol - sv), 64'd0);
        check_val("bp_hold",       64'(hold_viol - hv),  64'd0);
        tick();

        // Partial flush after the idle timeout.
        b = cap_dat.size(); fc = flush_cnt;
        for (int i = 0; i < 3; i++) push(32'hC000_0000 + DW'(i));
        push_cyc = cyc;
        wait_done("flush", 40);
        chk_burst("flush", b, 3, 32'hC000_0000);
        check_val("flush_cnt", 64'(flush_cnt - fc),       64'd1);
        check_val("flush_at",  64'(flush_cyc - push_cyc), 64'(TO));
        if (cap_edge.size() > b)
            check_val("flush_beat1", 64'(cap_edge[b] - push_cyc), 64'(TO + 2));
        tick();

        // Timer restart: count reaches BURST_LEN before the timeout.
        b = cap_dat.size(); bc = busy_cnt; fc = flush_cnt;
        push(32'hD000_0000);
        push(32'hD000_0001);
        repeat (5) tick();
        push(32'hD000_0002);
        push(32'hD000_0003);
        wait_done("restart", 40);
        chk_burst("restart", b, 4, 32'hD000_0000);
        check_val("restart_flush", 64'(flush_cnt - fc), 64'd0);
        check_val("restart_busy",  64'(busy_cnt - bc),  64'd5);
        tick();

        // Starvation: i_fifo_rvld drops for 3 cycles after beat 2.
        b = cap_dat.size(); fc = flush_cnt;
        for (int i = 0; i < 4; i++) push(32'hE000_0000 + DW'(i));
        wait_beats("starve", b, 2);
        starve = 1'b1;
        drive();
        repeat (3) tick();
        starve = 1'b0;
        drive();
        wait_done("starve", 40);
        chk_burst("starve", b, 4, 32'hE000_0000);
        check_val("starve_flush", 64'(flush_cnt - fc), 64'd0);
        if (cap_edge.size() >= b + 4)
            check_val("starve_span", 64'(cap_edge[b + 3] - cap_edge[b]), 64'd6);
        tick();

        // Asynchronous reset mid-burst, between clock edges.
        b = cap_dat.size();
        for (int i = 0; i < 4; i++) push(32'hF000_0000 + DW'(i));
        wait_beats("arst", b, 2);
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_vld",   64'(dut_vld),   64'd0);
        check_val("arst_last",  64'(dut_last),  64'd0);
        check_val("arst_dat",   64'(dut_dat),   64'd0);
        check_val("arst_rrdy",  64'(fifo_rrdy), 64'd0);
        check_val("arst_busy",  64'(dut_busy),  64'd0);
        check_val("arst_flush", 64'(dut_flush), 64'd0);
        tick();
        rst = 1'b0;
        q.delete();
        drive();
        tick();
        b = cap_dat.size(); bc = busy_cnt; fc = flush_cnt;
        for (int i = 0; i < 4; i++) push(32'h1200_0000 + DW'(i));
        wait_done("post_rst", 40);
        chk_burst("post_rst", b, 4, 32'h1200_0000);
        check_val("post_rst_busy",  64'(busy_cnt - bc),  64'd5);
        check_val("post_rst_flush", 64'(flush_cnt - fc), 64'd0);
        repeat (2) tick();

        check_val("noto_activity", 64'(z_act), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
